// File: rtl/bist_pkg.sv
// bist_pkg: shared constants, LFSR/MISR tap mask, default seed and FSM state type
//   WIDTH        - datapath width of pattern generator and signature register
//   TAP_MASK     - feedback taps at bit positions 0, 2, 3, 5 (x^16+x^14+x^13+x^11+1, right-shifting)
//   DEFAULT_SEED - power-on pattern seed (must be non-zero)
//   bist_state_e - IDLE / ARMED / COMPACT / DONE
package bist_pkg;
    localparam int WIDTH = 16;
    localparam logic [WIDTH-1:0] TAP_MASK = 16'h002D;
    localparam logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [7:0] COUNT_MAX = 8'hFF;

    typedef enum logic [1:0] {IDLE, ARMED, COMPACT, DONE} bist_state_e;

    // XOR of the tapped bits; shared by the LFSR and the MISR
    function automatic logic fb(input logic [WIDTH-1:0] v);
        return ^(v & TAP_MASK);
    endfunction
endpackage

// File: rtl/bist_lfsr.sv
// bist_lfsr: Fibonacci LFSR test-pattern generator
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset (state <- SEED)
//   load_i  - load seed_i (wins over en_i)
//   en_i    - advance one step
//   seed_i  - value loaded on load_i, also used to escape the all-zero lockup state
//   state_o - current pattern
module bist_lfsr import bist_pkg::*; #(
    parameter logic [WIDTH-1:0] SEED = DEFAULT_SEED
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] state_o
);
    logic [WIDTH-1:0] state_q, state_d;

    // all-zero is a lockup state; recover to the seed on the next edge
    always_comb begin
        state_d = state_q;
        if (load_i || state_q == '0)
            state_d = seed_i;
        else if (en_i)
            state_d = {fb(state_q), state_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= SEED;
        else
            state_q <= state_d;
    end

    assign state_o = state_q;
endmodule

// File: rtl/bist_signature.sv
// bist_signature: BIST pattern generation and MISR signature compaction with golden compare
//   CLK, RESET_N            - clock, asynchronous active-low reset
//   INIT, RUNNING, FINISH   - controller start pulse, compact enable, end pulse
//   CUT_RESP                - circuit-under-test response to the current PATTERN
//   PATTERN                 - LFSR test vector to the CUT
//   SIGNATURE               - MISR contents
//   PAT_COUNT               - compacted cycles since INIT, saturating at 255
//   SIG_VALID, PASS, FAIL   - final signature valid and comparison result
module bist_signature import bist_pkg::*; #(
    parameter logic [WIDTH-1:0] SEED   = DEFAULT_SEED,
    parameter logic [WIDTH-1:0] GOLDEN = 16'h0000
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             INIT,
    input  logic             RUNNING,
    input  logic             FINISH,
    input  logic [WIDTH-1:0] CUT_RESP,
    output logic [WIDTH-1:0] PATTERN,
    output logic [WIDTH-1:0] SIGNATURE,
    output logic [7:0]       PAT_COUNT,
    output logic             SIG_VALID,
    output logic             PASS,
    output logic             FAIL
);
    bist_state_e      state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             valid_q, valid_d, pass_q, pass_d, fail_q, fail_d;
    logic             load, step;

    bist_lfsr #(.SEED(SEED)) u_lfsr (
        .clk_i  (CLK),
        .rst_ni (RESET_N),
        .load_i (load),
        .en_i   (step),
        .seed_i (SEED),
        .state_o(PATTERN)
    );

    // priority INIT > FINISH > RUNNING; FINISH edge compares the already-final signature
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        load    = 1'b0;
        step    = 1'b0;
        if (INIT) begin
            state_d = ARMED;
            load    = 1'b1;
            sig_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
        end else if (state_q == ARMED || state_q == COMPACT) begin
            if (FINISH) begin
                state_d = DONE;
                valid_d = 1'b1;
                pass_d  = sig_q == GOLDEN;
                fail_d  = sig_q != GOLDEN;
            end else if (RUNNING) begin
                state_d = COMPACT;
                step    = 1'b1;
                sig_d   = {fb(sig_q), sig_q[WIDTH-1:1]} ^ CUT_RESP;
                cnt_d   = cnt_q == COUNT_MAX ? cnt_q : cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign SIGNATURE = sig_q;
    assign PAT_COUNT = cnt_q;
    assign SIG_VALID = valid_q;
    assign PASS      = pass_q;
    assign FAIL      = fail_q;
endmodule

// File: tb/tb_bist_signature.sv
// tb_bist_signature: directed and randomized checks of bist_signature against a behavioural model
module tb_bist_signature;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] GOLD = 16'h0000;

    logic        CLK = 1'b0, RESET_N = 1'b0, INIT = 1'b0, RUNNING = 1'b0, FINISH = 1'b0;
    logic [15:0] CUT_RESP = '0, PATTERN, SIGNATURE;
    logic [7:0]  PAT_COUNT;
    logic        SIG_VALID, PASS, FAIL;

    int n_tests = 0, n_fail = 0;

    // model: phase 0 idle, 1 armed, 2 compacting, 3 done
    int          m_phase, m_cnt;
    logic [15:0] m_pat, m_sig;
    bit          m_valid, m_pass, m_fail;

    bist_signature #(.SEED(SEED), .GOLDEN(GOLD)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .INIT(INIT), .RUNNING(RUNNING), .FINISH(FINISH),
        .CUT_RESP(CUT_RESP), .PATTERN(PATTERN), .SIGNATURE(SIGNATURE), .PAT_COUNT(PAT_COUNT),
        .SIG_VALID(SIG_VALID), .PASS(PASS), .FAIL(FAIL)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_pat = SEED; m_sig = '0;
        m_valid = 0; m_pass = 0; m_fail = 0;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] p);
        if (p == 16'h0000) return SEED;
        return {p[0] ^ p[2] ^ p[3] ^ p[5], p[15:1]};
    endfunction

    task automatic model_edge(input bit i, input bit r, input bit f, input logic [15:0] c);
        if (i) begin
            m_phase = 1; m_pat = SEED; m_sig = '0; m_cnt = 0;
            m_valid = 0; m_pass = 0; m_fail = 0;
        end else if (m_phase == 1 || m_phase == 2) begin
            if (f) begin
                m_phase = 3; m_valid = 1; m_pass = (m_sig == GOLD); m_fail = !m_pass;
            end else if (r) begin
                m_phase = 2;
                m_pat = lfsr_next(m_pat);
                m_sig = {m_sig[0] ^ m_sig[2] ^ m_sig[3] ^ m_sig[5], m_sig[15:1]} ^ c;
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
        end
    endtask

    task automatic check_all(input string t);
        check({t, ".pattern"}, 32'(PATTERN), 32'(m_pat));
        check({t, ".signature"}, 32'(SIGNATURE), 32'(m_sig));
        check({t, ".pat_count"}, 32'(PAT_COUNT), 32'(m_cnt));
        check({t, ".sig_valid"}, 32'(SIG_VALID), 32'(m_valid));
        check({t, ".pass"}, 32'(PASS), 32'(m_pass));
        check({t, ".fail"}, 32'(FAIL), 32'(m_fail));
    endtask

    task automatic cyc(input bit i, input bit r, input bit f, input logic [15:0] c);
        @(negedge CLK);
        INIT = i; RUNNING = r; FINISH = f; CUT_RESP = c;
        model_edge(i, r, f, c);
        @(posedge CLK);
        #1;
    endtask

    // reset asserted mid-cycle, away from any rising edge, to expose asynchronous behaviour
    task automatic do_reset(input string t);
        @(negedge CLK);
        RESET_N = 0; INIT = 0; RUNNING = 0; FINISH = 0; CUT_RESP = '0;
        model_reset();
        #1;
        check_all(t);
        @(negedge CLK);
        RESET_N = 1;
    endtask

    initial begin
        model_reset();
        do_reset("reset");

        cyc(1, 0, 0, '0);
        check_all("init");
        check("init.pattern_const", 32'(PATTERN), 32'h0000ACE1);

        cyc(0, 1, 0, '0);
        check_all("step1");
        check("step1.pattern_const", 32'(PATTERN), 32'h00005670);
        check("step1.count_const", 32'(PAT_COUNT), 32'd1);

        cyc(1, 0, 0, '0);
        for (int k = 0; k < 90; k++) cyc(0, 1, 0, '0);
        cyc(0, 0, 1, '0);
        check_all("golden90");
        check("golden90.count_const", 32'(PAT_COUNT), 32'd90);
        check("golden90.pass_const", 32'(PASS), 32'd1);
        cyc(0, 1, 0, 16'h1234);
        cyc(0, 0, 1, 16'h1234);
        check_all("done_hold");

        cyc(1, 0, 0, '0);
        cyc(0, 1, 0, 16'h0001);
        cyc(0, 0, 1, '0);
        check_all("bad1");
        check("bad1.sig_const", 32'(SIGNATURE), 32'h00000001);
        check("bad1.fail_const", 32'(FAIL), 32'd1);

        cyc(1, 0, 0, '0);
        cyc(0, 1, 0, 16'hBEEF);
        cyc(0, 1, 0, 16'h0F0F);
        cyc(1, 1, 1, 16'hFFFF);
        check_all("init_over_finish");
        check("init_over_finish.count_const", 32'(PAT_COUNT), 32'd0);
        cyc(0, 0, 0, 16'h5555);
        cyc(0, 1, 1, 16'h5555);
        check_all("finish_over_run");
        check("finish_over_run.pattern_const", 32'(PATTERN), 32'h0000ACE1);
        check("finish_over_run.valid_const", 32'(SIG_VALID), 32'd1);

        cyc(1, 0, 0, '0);
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, 16'(k * 37 + 1));
        cyc(0, 0, 0, 16'hAAAA);
        check_all("hold");
        do_reset("mid_reset");
        for (int k = 0; k < 300; k++) begin
            cyc(0, 1, k[0], 16'(k));
            check_all("post_reset_idle");
        end
        cyc(1, 0, 0, '0);
        for (int k = 0; k < 300; k++) cyc(0, 1, 0, 16'($urandom));
        check_all("saturate");
        check("saturate.count_const", 32'(PAT_COUNT), 32'd255);

        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 499) == 0)
                do_reset("rand_reset");
            else begin
                cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 29) == 0, 16'($urandom));
                check_all("random");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
